// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// Latches the winner's frame, holds newd until cs falls, then tracks the frame to cs release.
module spi_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               busy,
    output logic               newd,
    output logic [DW-1:0]      din,
    input  logic               cs_in
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [TW-1:0]   r_timer;
    logic            r_cs_meta;
    logic            r_cs_s;
    logic [1:0]      r_hold;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic            r_busy;
    logic            r_newd;
    logic [DW-1:0]   r_din;

    logic [PW-1:0]   w_win;
    logic            w_found;
    logic            w_expire;
    int              w_idx;

    // Descending scan so the nearest requester after r_ptr is the last one assigned.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    assign w_expire = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= PW'(NREQ - 1);
            r_timer   <= '0;
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
            r_hold    <= 2'd2;
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_newd    <= 1'b0;
            r_din     <= '0;
        end else begin
            r_cs_meta <= cs_in;
            r_cs_s    <= r_cs_meta;
            // The synchronizer comes out of reset reading "idle"; wait until it reflects the real cs.
            if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_timer <= (r_state == S_IDLE) ? '0 : r_timer + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_hold == 2'd0 && w_found && r_cs_s) begin
                        r_din          <= req_data[w_win*DW +: DW];
                        r_grant[w_win] <= 1'b1;
                        r_ptr          <= w_win;
                        r_newd         <= 1'b1;
                        r_busy         <= 1'b1;
                        r_timer        <= '0;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!r_cs_s) begin
                        r_newd  <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_XFER;
                    end else if (w_expire) begin
                        r_newd       <= 1'b0;
                        r_err[r_ptr] <= 1'b1;
                        r_busy       <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (r_cs_s) begin
                        r_done[r_ptr] <= 1'b1;
                        r_busy        <= 1'b0;
                        r_timer       <= '0;
                        r_state       <= S_IDLE;
                    end else if (w_expire) begin
                        r_err[r_ptr] <= 1'b1;
                        r_busy       <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_newd  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign err   = r_err;
    assign busy  = r_busy;
    assign newd  = r_newd;
    assign din   = r_din;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter with a behavioural SPI master driving cs_in.
module tb_spi_req_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant, done, err;
    logic               busy, newd;
    logic [DW-1:0]      din;
    logic               cs_in;
    bit                 m_en;

    int checks = 0;
    int errors = 0;
    int n_grant = 0;

    typedef struct {
        int          kind;
        int          idx;
        logic [11:0] data;
    } exp_t;
    exp_t q[$];

    spi_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .newd(newd), .din(din), .cs_in(cs_in)
    );

    always #5 clk = ~clk;

    task automatic push(input int k, input int i, input logic [11:0] d);
        exp_t e;
        e.kind = k; e.idx = i; e.data = d;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_evt(input int k, input logic [NREQ-1:0] v);
        exp_t e;
        logic [NREQ-1:0] oh;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected kind=%0d vec=%b expected=none", k, v);
        end else begin
            e  = q.pop_front();
            oh = 4'b0001 << e.idx;
            if (e.kind != k || v !== oh || din !== e.data) begin
                errors++;
                $display("FAIL evt kind=%0d vec=%b din=%h expected kind=%0d vec=%b din=%h",
                         k, v, din, e.kind, oh, e.data);
            end
        end
    endtask

    // Monitor: every grant/done/err pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (grant != 0) begin n_grant++; check_evt(0, grant); end
        if (done != 0) check_evt(1, done);
        if (err != 0) check_evt(2, err);
    end

    // Behavioural SPI master: answers newd by dropping cs for a fixed frame length.
    initial begin
        cs_in = 1'b1;
        forever begin
            @(posedge clk);
            if (m_en && newd && cs_in && !rst) begin
                repeat (3) @(posedge clk);
                #1 cs_in = 1'b0;
                repeat (30) @(posedge clk);
                #1 cs_in = 1'b1;
            end
        end
    end

    task automatic wait_pulse(input int k, input string nm);
        int  t = 0;
        bit  seen = 0;
        while (!seen && t < 3000) begin
            @(negedge clk);
            t++;
            seen = (k == 0) ? (grant != 0) : (k == 1) ? (done != 0) : (err != 0);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=none expected=pulse", nm);
        end
    endtask

    task automatic wait_cs(input logic lvl, input string nm);
        int t = 0;
        while (cs_in !== lvl && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cs_in !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=%b expected=%b", nm, cs_in, lvl);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int t;
        int g0;
        rst = 1'b1; req = '0; req_data = '0; m_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_newd", newd, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        // All four requesting: ptr starts at NREQ-1 so order is 0,1,2,3,0.
        req_data = {12'h444, 12'h333, 12'h222, 12'h111};
        push(0, 0, 12'h111); push(1, 0, 12'h111);
        push(0, 1, 12'h222); push(1, 1, 12'h222);
        push(0, 2, 12'h333); push(1, 2, 12'h333);
        push(0, 3, 12'h444); push(1, 3, 12'h444);
        push(0, 0, 12'h111); push(1, 0, 12'h111);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_pulse(0, "rr_grant");
            if (i == 4) req = '0;
            wait_pulse(1, "rr_done");
        end

        // ptr=0 with req=0011: requester 1 goes before requester 0.
        push(0, 1, 12'h222); push(1, 1, 12'h222);
        push(0, 0, 12'h111); push(1, 0, 12'h111);
        req = 4'b0011;
        wait_pulse(0, "pair_grant1");
        wait_pulse(1, "pair_done1");
        wait_pulse(0, "pair_grant0");
        req = '0;
        wait_pulse(1, "pair_done0");

        // Single request: grant one cycle after req.
        req_data[11:0] = 12'hA5C;
        push(0, 0, 12'hA5C); push(1, 0, 12'hA5C);
        repeat (3) @(posedge clk);
        #1 req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("single_grant_latency", grant, 4'b0001);
        req = '0;
        wait_pulse(1, "single_done");
        chk("single_busy_after_done", busy, 0);

        // Requester 2 drops req one cycle after grant and changes its data.
        req_data[35:24] = 12'h3C7;
        push(0, 2, 12'h3C7); push(1, 2, 12'h3C7);
        req = 4'b0100;
        wait_pulse(0, "drop_grant");
        @(posedge clk); #1 req = '0; req_data[35:24] = 12'hFFF;
        wait_pulse(1, "drop_done");

        // Master disconnected: newd held for TIMEOUT cycles then err.
        m_en = 1'b0;
        push(0, 0, 12'hA5C); push(2, 0, 12'hA5C);
        req = 4'b0001;
        wait_pulse(0, "to_grant");
        req = '0;
        cnt = 0; t = 0;
        while (newd && t < 500) begin
            cnt++;
            @(negedge clk);
            t++;
        end
        chk("to_newd_cycles", cnt, 64);
        chk("to_err", err, 4'b0001);
        chk("to_busy", busy, 0);
        m_en = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-XFER with requester 1 still requesting.
        req_data[23:12] = 12'h222;
        push(0, 1, 12'h222);
        req = 4'b0010;
        wait_pulse(0, "rstx_grant");
        wait_cs(1'b0, "rstx_cs_fall");
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstx_newd", newd, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_grant", grant, 0);
        push(0, 1, 12'h222); push(1, 1, 12'h222);
        g0 = n_grant;
        wait_cs(1'b1, "rstx_cs_rise");
        chk("rstx_no_grant_while_cs_low", n_grant, g0);
        wait_pulse(0, "rstx_regrant");
        req = '0;
        wait_pulse(1, "rstx_done");

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
